// File: rtl/sram_chip_responder.sv
// sram_chip_responder: device-side responder for a 256K x 16 asynchronous SRAM
// pin interface. Holds the word array, answers reads either combinationally
// or through a short read pipeline, optionally zero-fills the array after
// reset, and keeps write/read beat counters plus an early-access flag.
//
// Init FSM
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_CLEAR | zero-fill sweep in progress (or the single cycle leaving
//            | reset when no sweep is configured); accesses are rejected
//   ST_READY | array usable; init_done high until the next reset
module sram_chip_responder #(
  parameter int ADDR_W         = 18,
  parameter int READ_LAT       = 0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] SRAM_DQ,
  input  logic [17:0] SRAM_ADDR,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_LB_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_OE_N,
  output logic        init_done,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic        err_access_during_init
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              clr_we;

  logic [15:0]       mem [DEPTH];

  logic [ADDR_W-1:0] addr;
  logic              wc;
  logic              rc;
  logic              wr_hit;
  logic              rd_hit;
  logic              early_access;
  logic [15:0]       rd_word;

  logic              drv_hi;
  logic              drv_lo;
  logic [15:0]       dout;

  // Upper address bits beyond ADDR_W alias; folded here so they are consumed.
  logic              unused_addr;
  assign unused_addr = ^SRAM_ADDR;

  assign addr    = SRAM_ADDR[ADDR_W-1:0];
  assign rd_word = mem[addr];

  // A write needs only CE and WE; WE low wins over OE, so a read is WE high.
  assign wc = ~SRAM_CE_N & ~SRAM_WE_N;
  assign rc = ~SRAM_CE_N & ~SRAM_OE_N & SRAM_WE_N;

  assign wr_hit       = init_done & wc;
  assign rd_hit       = init_done & rc;
  assign early_access = ~init_done & (wc | rc);

  // Init FSM state register; reset always lands in the clear state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Leave the sweep after the last word, or at once when no sweep is wanted.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR) begin
      if (!CLEAR_ON_RESET || (clr_ptr_q == PTR_LAST)) begin
        state_d = ST_READY;
      end
    end
  end

  // FSM outputs: ready flag and sweep write strobe.
  always_comb begin
    init_done = 1'b0;
    clr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: clr_we    = CLEAR_ON_RESET;
      ST_READY: init_done = 1'b1;
      default:  init_done = 1'b0;
    endcase
  end

  // Sweep pointer walks the whole array once, restarting from zero on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_ptr_q <= '0;
    end else if (clr_we) begin
      clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
    end
  end

  // Array write port: sweep zero-fill, otherwise byte-masked host writes.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ptr_q] <= 16'h0000;
    end else if (wr_hit) begin
      if (!SRAM_UB_N) mem[addr][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LB_N) mem[addr][7:0]  <= SRAM_DQ[7:0];
    end
  end

  // Beat counters (free-running wrap) and the sticky early-access flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count               <= 16'h0000;
      rd_count               <= 16'h0000;
      err_access_during_init <= 1'b0;
    end else begin
      if (wr_hit)       wr_count               <= wr_count + 16'd1;
      if (rd_hit)       rd_count               <= rd_count + 16'd1;
      if (early_access) err_access_during_init <= 1'b1;
    end
  end

  generate
    if (READ_LAT == 0) begin : g_comb_read
      // Asynchronous-SRAM behaviour: data follows the address immediately.
      always_comb begin
        drv_hi = rd_hit & ~SRAM_UB_N;
        drv_lo = rd_hit & ~SRAM_LB_N;
        dout   = rd_word;
      end
    end else begin : g_pipe_read
      typedef struct packed {
        logic        valid;
        logic        ub_n;
        logic        lb_n;
        logic [15:0] data;
      } stage_t;

      stage_t pipe_q [READ_LAT];

      // Capture the pre-write array word with its masks, then shift each clock.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < READ_LAT; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q[0] <= {rd_hit, SRAM_UB_N, SRAM_LB_N, rd_word};
          for (int i = 1; i < READ_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      // Drive from the last stage using the masks captured with the data.
      always_comb begin
        drv_hi = pipe_q[READ_LAT-1].valid & ~pipe_q[READ_LAT-1].ub_n;
        drv_lo = pipe_q[READ_LAT-1].valid & ~pipe_q[READ_LAT-1].lb_n;
        dout   = pipe_q[READ_LAT-1].data;
      end
    end
  endgenerate

  assign SRAM_DQ[15:8] = drv_hi ? dout[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = drv_lo ? dout[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_chip_responder.sv
// Bench for sram_chip_responder: two instances (combinational read and
// two-clock read latency) share every control pin and see identical traffic
// on separate data buses. Undriven bus bytes float high through pullups, so a
// released byte reads as 8'hFF.
module tb_sram_chip_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;
  logic        tb_oe;
  logic [15:0] tb_dq;

  wire  [15:0] dq0;
  wire  [15:0] dq2;

  logic        init0, init2, err0, err2;
  logic [15:0] wr0, wr2, rd0, rd2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign dq0 = tb_oe ? tb_dq : 16'hzzzz;
  assign dq2 = tb_oe ? tb_dq : 16'hzzzz;

  for (genvar gi = 0; gi < 16; gi++) begin : g_pull
    pullup (dq0[gi]);
    pullup (dq2[gi]);
  end

  sram_chip_responder #(.ADDR_W(4), .READ_LAT(0), .CLEAR_ON_RESET(1'b1)) u_lat0 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq0), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n),
    .SRAM_OE_N(oe_n), .init_done(init0), .wr_count(wr0), .rd_count(rd0),
    .err_access_during_init(err0));

  sram_chip_responder #(.ADDR_W(4), .READ_LAT(2), .CLEAR_ON_RESET(1'b1)) u_lat2 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq2), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n),
    .SRAM_OE_N(oe_n), .init_done(init2), .wr_count(wr2), .rd_count(rd2),
    .err_access_during_init(err2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] masked(input logic [15:0] w, input logic u, input logic l);
    return {u ? 8'hFF : w[15:8], l ? 8'hFF : w[7:0]};
  endfunction

  // ---------------- behavioural model ----------------
  logic [15:0] m_mem [16];
  bit          m_ready;
  int          m_edges;
  logic [15:0] m_wr, m_rd;
  bit          m_err;
  logic [15:0] m_cap1, m_exp2;
  bit          m_wc, m_rc;
  logic [15:0] m_cap;

  task automatic model_reset();
    m_ready = 0; m_edges = 0; m_wr = 0; m_rd = 0; m_err = 0;
    m_cap1 = 16'hFFFF; m_exp2 = 16'hFFFF;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset();
      end else begin
        m_wc  = !ce_n && !we_n;
        m_rc  = !ce_n && !oe_n && we_n;
        m_cap = (m_rc && m_ready) ? masked(m_mem[addr[3:0]], ub_n, lb_n) : 16'hFFFF;
        // Two-clock latency: a read captured at one edge appears after the next.
        m_exp2 = m_cap1;
        m_cap1 = m_cap;
        if (m_ready) begin
          if (m_wc) begin
            if (!ub_n) m_mem[addr[3:0]][15:8] = tb_dq[15:8];
            if (!lb_n) m_mem[addr[3:0]][7:0]  = tb_dq[7:0];
            m_wr++;
          end
          if (m_rc) m_rd++;
        end else begin
          if (m_wc || m_rc) m_err = 1;
          m_edges++;
          if (m_edges == 16) begin
            m_ready = 1;
            for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [15:0] e0, e2;
    bit rc_now;
    @(posedge clk);
    forever begin
      @(negedge clk);
      rc_now = !ce_n && !oe_n && we_n;
      e0 = tb_oe ? tb_dq : ((rc_now && m_ready) ? masked(m_mem[addr[3:0]], ub_n, lb_n) : 16'hFFFF);
      e2 = tb_oe ? tb_dq : m_exp2;
      check("init_done_l0", init0, m_ready);
      check("init_done_l2", init2, m_ready);
      check("wr_count_l0", wr0, m_wr);
      check("wr_count_l2", wr2, m_wr);
      check("rd_count_l0", rd0, m_rd);
      check("rd_count_l2", rd2, m_rd);
      check("err_l0", err0, m_err);
      check("err_l2", err2, m_err);
      check("dq_l0", dq0, e0);
      check("dq_l2", dq2, e2);
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] s0, s2;

  task automatic cyc();
    @(negedge clk);
    s0 = dq0;
    s2 = dq2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce_n = 1; we_n = 1; oe_n = 1; ub_n = 0; lb_n = 0; tb_oe = 0;
    cyc();
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic u,
                    input logic l, input logic oe);
    addr = a; tb_dq = d; tb_oe = 1; ce_n = 0; we_n = 0; oe_n = oe; ub_n = u; lb_n = l;
    cyc();
  endtask

  task automatic rd(input logic [17:0] a, input logic u, input logic l);
    addr = a; tb_oe = 0; ce_n = 0; we_n = 1; oe_n = 0; ub_n = u; lb_n = l;
    cyc();
  endtask

  task automatic wait_ready(output int n);
    ce_n = 1; we_n = 1; oe_n = 1; tb_oe = 0;
    n = 0;
    while (!init0 && n < 40) begin
      @(posedge clk);
      n++;
      #1;
    end
  endtask

  initial begin
    int n;
    logic [15:0] w0 [4];
    logic [15:0] w2 [4];
    addr = 0; tb_dq = 0; tb_oe = 0;
    ce_n = 1; we_n = 1; oe_n = 1; ub_n = 0; lb_n = 0;
    #1 rst = 0;
    @(posedge clk); #1;
    idle(); idle();
    check("reset_init_done", init0, 1'b0);
    check("reset_wr_count", wr0, 16'd0);
    check("reset_rd_count", rd0, 16'd0);
    check("reset_err", err0, 1'b0);

    // First sweep, then fill with all-ones so the next sweep has work to do.
    rst = 1;
    wait_ready(n);
    check("sweep_len", n, 16);
    for (int i = 0; i < 16; i++) wr(18'(i), 16'hFFFF, 1'b0, 1'b0, 1'b1);
    idle();

    // Abort a sweep at clock 7, then let it run to completion.
    rst = 0; idle(); idle(); rst = 1;
    repeat (7) idle();
    rst = 0;
    idle();
    check("abort_init_done", init0, 1'b0);
    rst = 1;
    wait_ready(n);
    check("sweep_len_restart", n, 16);
    for (int i = 0; i < 16; i++) begin
      rd(18'(i), 1'b0, 1'b0);
      check("cleared_word", s0, 16'h0000);
    end
    idle(); idle();

    // Byte-masked writes, WE overriding OE, masked-off write still counted.
    wr(18'd6, 16'hAAAA, 1'b0, 1'b0, 1'b1);
    wr(18'd5, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    wr(18'd6, 16'h1234, 1'b1, 1'b0, 1'b1);
    wr(18'd7, 16'h5555, 1'b1, 1'b1, 1'b1);
    idle();
    check("wr_count_4", wr0, 16'd4);
    rd(18'd5, 1'b0, 1'b0);       check("read5", s0, 16'hBEEF);
    rd(18'd6, 1'b0, 1'b0);       check("read6_ub_kept", s0, 16'hAA34);
    rd(18'd7, 1'b0, 1'b0);       check("read7_no_bytes", s0, 16'h0000);
    rd(18'h3FFF5, 1'b0, 1'b0);   check("read_alias", s0, 16'hBEEF);
    idle();
    check("rd_count_20", rd0, 16'd20);
    idle();

    // Read byte masks.
    rd(18'd5, 1'b1, 1'b0);       check("read_lb_only", s0, 16'hFFEF);
    rd(18'd5, 1'b0, 1'b1);       check("read_ub_only", s0, 16'hBEFF);
    idle();
    check("rd_count_22", rd0, 16'd22);
    idle(); idle();

    // Latency 2 window and read-before-write of the following write.
    rd(18'd5, 1'b0, 1'b0);       check("lat2_early", s2, 16'hFFFF);
    wr(18'd5, 16'h0001, 1'b0, 1'b0, 1'b1);
    idle();                      check("lat2_data", s2, 16'hBEEF);
    idle();                      check("lat2_release", s2, 16'hFFFF);
    rd(18'd5, 1'b0, 1'b0);       check("write_landed", s0, 16'h0001);
    idle(); idle();

    // Accesses during the sweep.
    rst = 0; idle(); rst = 1;
    repeat (8) idle();
    wr(18'd2, 16'h1234, 1'b0, 1'b0, 1'b1);
    rd(18'd2, 1'b0, 1'b0);       check("init_read_z", s0, 16'hFFFF);
    idle();
    check("init_err", err0, 1'b1);
    check("init_wr_count", wr0, 16'd0);
    check("init_rd_count", rd0, 16'd0);
    wait_ready(n);
    check("sweep_len_busy", n, 5);
    rd(18'd2, 1'b0, 1'b0);       check("init_write_ignored", s0, 16'h0000);
    idle();
    check("err_sticky", err0, 1'b1);
    rst = 0; idle(); rst = 1;
    wait_ready(n);
    check("err_cleared", err0, 1'b0);
    idle();

    // Controller-style 32-bit writes at byte 8 and 12, 64-bit burst read at byte 8.
    wr(18'd4, 16'hF00D, 1'b0, 1'b0, 1'b1);
    wr(18'd5, 16'hCAFE, 1'b0, 1'b0, 1'b1);
    wr(18'd6, 16'h4567, 1'b0, 1'b0, 1'b1);
    wr(18'd7, 16'h0123, 1'b0, 1'b0, 1'b1);
    idle(); idle();
    rd(18'd4, 1'b0, 1'b0); w0[0] = s0;
    rd(18'd5, 1'b0, 1'b0); w0[1] = s0;
    rd(18'd6, 1'b0, 1'b0); w0[2] = s0; w2[0] = s2;
    rd(18'd7, 1'b0, 1'b0); w0[3] = s0; w2[1] = s2;
    idle();                w2[2] = s2;
    idle();                w2[3] = s2;
    check("burst64_l0", {w0[3], w0[2], w0[1], w0[0]}, 64'h01234567CAFEF00D);
    check("burst64_l2", {w2[3], w2[2], w2[1], w2[0]}, 64'h01234567CAFEF00D);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
